lcd_timing_gen: RTL
===================

Name: lcd_timing_gen

Overview:
- Parametrised LCD raster timing generator. It is the successor to the fixed-geometry sync block.
- Generates HSYNC, VSYNC and DEN from full porch/sync parameters with selectable sync polarity, together with pixel coordinates and line/frame strobes.
- A run/stop control stops scanning only at a frame boundary.
- A built-in backlight PWM takes a glitch-free duty update.
- Sits between the pixel-clock PLL output and the pixel data source.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, HSYNC width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, VSYNC width (lines)
- V_BP, 2, vertical back porch (lines)
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level (0 = active-low)
- CW, 11, width of counters and X/Y
- PWM_BITS, 8, backlight PWM resolution

Ports:
- CLK  in  1  pixel clock; the only clock
- RST_IN  in  1  synchronous, active-low reset
- EN  in  1  run request
- PWM_DUTY  in  PWM_BITS  backlight duty (on-count per PWM period)
- LCD_HSYNC  out  1  horizontal sync, polarity per HS_POL
- LCD_VSYNC  out  1  vertical sync, polarity per VS_POL
- LCD_DEN  out  1  data enable, active-high
- LCD_PWM  out  1  backlight PWM
- X  out  CW  active pixel column; 0 outside the active area
- Y  out  CW  active line; 0 outside the active area
- LINE_START  out  1  one-cycle pulse at the first pixel of each active line
- FRAME_START  out  1  one-cycle pulse at pixel (0,0)
- RUNNING  out  1  high while in RUN or DRAIN

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - Both totals must be <= 2^CW. Each phase parameter must be >= 1.
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1):
  - h increments every RUN/DRAIN clock.
  - At H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with h = H_TOTAL-1, the frame ends.
- Horizontal line order: active [0, H_ACTIVE), FP, SYNC, BP. Vertical frame order is the same, measured in whole lines.
- All outputs are registered and aligned to the (h,v) of the same cycle:
  - DEN = (h < H_ACTIVE) && (v < V_ACTIVE)
  - HSYNC asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - VSYNC asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
  - X = DEN ? h : 0; Y = DEN ? v : 0
  - LINE_START = (h == 0) && (v < V_ACTIVE)
  - FRAME_START = (h == 0) && (v == 0)
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: h = v = 0; DEN = 0; syncs inactive; X = Y = 0; strobes = 0; RUNNING = 0. EN = 1 sampled in IDLE moves to RUN. The first RUN cycle shows (0,0) with FRAME_START = 1. Latency from EN to first pixel is 1 clock.
  - RUN: EN = 0 moves to DRAIN, and counting continues.
  - DRAIN: EN = 1 returns to RUN with no timing disturbance.
  - End of frame in RUN: wrap to (0,0) and stay in RUN.
  - End of frame in DRAIN: go to IDLE. The next cycle shows IDLE outputs.
- Reset (RST_IN = 0 at a rising CLK edge): next cycle is IDLE with all outputs at their IDLE values, LCD_PWM = 0, PWM counter = 0, latched duty = 0. This applies mid-frame with no completion.
- PWM:
  - Free-running PWM_BITS counter p, running in every state after reset.
  - Duty is latched from PWM_DUTY only when p wraps to 0, so mid-period changes have no effect until the next period.
  - LCD_PWM = (p < duty_latched), registered.
  - Duty 0 gives constant low. Duty 2^PWM_BITS-1 gives high for all but one clock per period.

Test Plan (bench parameters: H 4/1/2/1, H_TOTAL = 8; V 3/1/1/1, V_TOTAL = 6; frame = 48 clocks; polarities 0; PWM_BITS = 3):
- Release reset, EN = 0 for 10 clocks -> RUNNING = 0, DEN = 0, HSYNC = VSYNC = 1, X = Y = 0.
- Raise EN at cycle t -> at t+1: FRAME_START = 1, DEN = 1, X = 0, Y = 0. DEN is high for 4 clocks with X = 0,1,2,3. HSYNC is low exactly at h = 5,6. LINE_START fires at h = 0 of v = 0,1,2.
- Hold EN = 1 for 2 frames -> VSYNC is low for the 8 clocks of v = 4. FRAME_START pulses every 48 clocks. DEN is 0 for all of v = 3..5.
- Drop EN at frame cycle 20 -> the frame completes (RUNNING falls after cycle 47) and then outputs hold IDLE values. Re-raising EN at cycle 30 instead -> no gap, and the next FRAME_START arrives at cycle 48.
- Pulse RST_IN low at frame cycle 13 (h = 5, v = 1) -> the next cycle shows IDLE outputs, LCD_PWM = 0, HSYNC = 1.
- PWM_DUTY = 3, then change to 6 at p = 2 -> LCD_PWM is high for 3 of 8 clocks in the current period and 6 of 8 from the next period. PWM_DUTY = 0 -> constant low.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - parametrised LCD raster timing generator with backlight PWM
//
// Generates HSYNC/VSYNC/DEN, pixel coordinates and line/frame strobes from
// porch/sync parameters. A run/stop request stops scanning only at a frame
// boundary. A free-running PWM drives the backlight, and its duty is taken
// only at period boundaries.
//
// Ports:
//   CLK          pixel clock (only clock)
//   RST_IN       synchronous active-low reset
//   EN           run request
//   PWM_DUTY     backlight on-count per PWM period
//   LCD_HSYNC    horizontal sync, active level HS_POL
//   LCD_VSYNC    vertical sync, active level VS_POL
//   LCD_DEN      data enable, active-high
//   LCD_PWM      backlight PWM output
//   X, Y         active pixel column/line, 0 outside the active area
//   LINE_START   pulse at the first pixel of each active line
//   FRAME_START  pulse at pixel (0,0)
//   RUNNING      high while scanning (RUN or DRAIN)
module lcd_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11,
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST_IN,
  input  logic                EN,
  input  logic [PWM_BITS-1:0] PWM_DUTY,
  output logic                LCD_HSYNC,
  output logic                LCD_VSYNC,
  output logic                LCD_DEN,
  output logic                LCD_PWM,
  output logic [CW-1:0]       X,
  output logic [CW-1:0]       Y,
  output logic                LINE_START,
  output logic                FRAME_START,
  output logic                RUNNING
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, den_q, den_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic running_q, running_d;
  logic [PWM_BITS-1:0] p_q, p_d, duty_q, duty_d;
  logic pwm_q, pwm_d;
  logic h_wrap, frame_end;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    h_wrap    = (h_q == H_LAST);
    frame_end = h_wrap && (v_q == V_LAST);

    case (state_q)
      S_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (EN) state_d = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        if (h_wrap) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        if (state_q == S_RUN) begin
          if (!EN) state_d = S_DRAIN;
        end else if (EN) begin
          // Re-arming while draining keeps the raster running untouched.
          state_d = S_RUN;
        end else if (frame_end) begin
          state_d = S_IDLE;
          h_d     = '0;
          v_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase

    // Outputs are decoded from the next (h,v) so the registered values line
    // up with the counters in the same cycle.
    running_d     = (state_d != S_IDLE);
    den_d         = running_d && (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d       = (running_d && (h_d >= HS_START) && (h_d < HS_END)) ? HS_ON : ~HS_ON;
    vsync_d       = (running_d && (v_d >= VS_START) && (v_d < VS_END)) ? VS_ON : ~VS_ON;
    x_d           = den_d ? h_d : '0;
    y_d           = den_d ? v_d : '0;
    line_start_d  = running_d && (h_d == '0) && (v_d < V_ACT);
    frame_start_d = running_d && (h_d == '0) && (v_d == '0);

    // Duty is sampled only as the counter wraps, so a period never sees a
    // partial update.
    p_d    = p_q + 1'b1;
    duty_d = (p_d == '0) ? PWM_DUTY : duty_q;
    pwm_d  = (p_d < duty_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_IN) begin
      state_q       <= S_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      den_q         <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
      p_q           <= '0;
      duty_q        <= '0;
      pwm_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      den_q         <= den_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
      p_q           <= p_d;
      duty_q        <= duty_d;
      pwm_q         <= pwm_d;
    end
  end

  assign LCD_HSYNC   = hsync_q;
  assign LCD_VSYNC   = vsync_q;
  assign LCD_DEN     = den_q;
  assign LCD_PWM     = pwm_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;
  assign RUNNING     = running_q;

endmodule
